// File: rtl/idu_inst_buffer.sv
// Circular instruction buffer between the IFU and the decoder.
// Accepts two-entry fetch bundles, presents the two oldest entries per cycle.
module idu_inst_buffer #(
    parameter int PC_WIDTH   = 32,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int PTR_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ifu_idu_pipe_vld,
    input  logic [PC_WIDTH-1:0]   ifu_idu_pc_1,
    input  logic [PC_WIDTH-1:0]   ifu_idu_pc_2,
    input  logic [INST_WIDTH-1:0] ifu_idu_inst_1,
    input  logic [INST_WIDTH-1:0] ifu_idu_inst_2,
    input  logic                  ifu_idu_pc_unalign_1,
    input  logic                  ifu_idu_pc_unalign_2,
    input  logic                  iex_ifu_bru_flush,
    input  logic [1:0]            dec_ibuf_pop,
    output logic                  idu_ifu_instBuffer_full,
    output logic                  ibuf_dec_vld_1,
    output logic                  ibuf_dec_vld_2,
    output logic [PC_WIDTH-1:0]   ibuf_dec_pc_1,
    output logic [PC_WIDTH-1:0]   ibuf_dec_pc_2,
    output logic [INST_WIDTH-1:0] ibuf_dec_inst_1,
    output logic [INST_WIDTH-1:0] ibuf_dec_inst_2,
    output logic                  ibuf_dec_unalign_1,
    output logic                  ibuf_dec_unalign_2,
    output logic [PTR_W:0]        ibuf_count,
    output logic                  ibuf_overflow
);

    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        logic [INST_WIDTH-1:0] inst;
        logic                  unalign;
    } entry_t;

    localparam logic [PTR_W:0] FULL_THR = (PTR_W+1)'(DEPTH - 2);
    localparam logic [PTR_W:0] TWO      = (PTR_W+1)'(2);

    entry_t             mem_q [DEPTH];
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic               ovf_q, ovf_d;
    logic [PTR_W:0]     count;
    logic               full;
    logic               push_en;
    logic [1:0]         pop_req;
    logic [PTR_W:0]     pop_eff;
    logic [PTR_W-1:0]   wr_idx_1, wr_idx_2, rd_idx_1, rd_idx_2;
    entry_t             head_1, head_2;

    // Wrap bit in the pointer MSB makes the modular difference the occupancy.
    assign count    = wr_ptr_q - rd_ptr_q;
    assign full     = count > FULL_THR;
    assign push_en  = ifu_idu_pipe_vld && !full && !iex_ifu_bru_flush;
    assign pop_req  = (dec_ibuf_pop == 2'd3) ? 2'd2 : dec_ibuf_pop;
    assign pop_eff  = ((PTR_W+1)'(pop_req) > count) ? count : (PTR_W+1)'(pop_req);

    assign wr_idx_1 = wr_ptr_q[PTR_W-1:0];
    assign wr_idx_2 = PTR_W'(wr_ptr_q + 1'b1);
    assign rd_idx_1 = rd_ptr_q[PTR_W-1:0];
    assign rd_idx_2 = PTR_W'(rd_ptr_q + 1'b1);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        ovf_d    = ovf_q;
        if (iex_ifu_bru_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + pop_eff;
            if (push_en)
                wr_ptr_d = wr_ptr_q + TWO;
            if (ifu_idu_pipe_vld && full)
                ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage carries no reset; stale contents are hidden by the vld masking.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_idx_1] <= '{pc: ifu_idu_pc_1, inst: ifu_idu_inst_1,
                                 unalign: ifu_idu_pc_unalign_1};
            mem_q[wr_idx_2] <= '{pc: ifu_idu_pc_2, inst: ifu_idu_inst_2,
                                 unalign: ifu_idu_pc_unalign_2};
        end
    end

    assign ibuf_dec_vld_1 = (count >= (PTR_W+1)'(1));
    assign ibuf_dec_vld_2 = (count >= TWO);
    assign head_1         = ibuf_dec_vld_1 ? mem_q[rd_idx_1] : '0;
    assign head_2         = ibuf_dec_vld_2 ? mem_q[rd_idx_2] : '0;

    assign ibuf_dec_pc_1           = head_1.pc;
    assign ibuf_dec_pc_2           = head_2.pc;
    assign ibuf_dec_inst_1         = head_1.inst;
    assign ibuf_dec_inst_2         = head_2.inst;
    assign ibuf_dec_unalign_1      = head_1.unalign;
    assign ibuf_dec_unalign_2      = head_2.unalign;
    assign ibuf_count              = count;
    assign ibuf_overflow           = ovf_q;
    assign idu_ifu_instBuffer_full = full;

endmodule

// File: tb/tb_idu_inst_buffer.sv
// Scoreboard bench for idu_inst_buffer: a reference queue tracks what the
// buffer should hold and every visible output is checked each cycle.
module tb_idu_inst_buffer;

    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ua;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_vld = 1'b0;
    logic [31:0] pc_1 = '0, pc_2 = '0, inst_1 = '0, inst_2 = '0;
    logic        ua_1 = 1'b0, ua_2 = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  pop = 2'd0;
    logic        full, vld_1, vld_2, dua_1, dua_2, ovf;
    logic [31:0] dpc_1, dpc_2, dinst_1, dinst_2;
    logic [3:0]  count;

    ent_t sb[$];
    logic m_ovf = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    idu_inst_buffer #(.PC_WIDTH(32), .INST_WIDTH(32), .DEPTH(DEPTH), .PTR_W(3)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .ifu_idu_pipe_vld        (pipe_vld),
        .ifu_idu_pc_1            (pc_1),
        .ifu_idu_pc_2            (pc_2),
        .ifu_idu_inst_1          (inst_1),
        .ifu_idu_inst_2          (inst_2),
        .ifu_idu_pc_unalign_1    (ua_1),
        .ifu_idu_pc_unalign_2    (ua_2),
        .iex_ifu_bru_flush       (flush),
        .dec_ibuf_pop            (pop),
        .idu_ifu_instBuffer_full (full),
        .ibuf_dec_vld_1          (vld_1),
        .ibuf_dec_vld_2          (vld_2),
        .ibuf_dec_pc_1           (dpc_1),
        .ibuf_dec_pc_2           (dpc_2),
        .ibuf_dec_inst_1         (dinst_1),
        .ibuf_dec_inst_2         (dinst_2),
        .ibuf_dec_unalign_1      (dua_1),
        .ibuf_dec_unalign_2      (dua_2),
        .ibuf_count              (count),
        .ibuf_overflow           (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the reference queue at the current cycle.
    task automatic check_outputs();
        int   n;
        ent_t e1, e2;
        n  = sb.size();
        e1 = '{pc: '0, inst: '0, ua: 1'b0};
        e2 = '{pc: '0, inst: '0, ua: 1'b0};
        if (n >= 1) e1 = sb[0];
        if (n >= 2) e2 = sb[1];
        chk("count",  64'(count), 64'(n));
        chk("full",   64'(full),  64'(n > DEPTH - 2));
        chk("ovf",    64'(ovf),   64'(m_ovf));
        chk("vld_1",  64'(vld_1), 64'(n >= 1));
        chk("vld_2",  64'(vld_2), 64'(n >= 2));
        chk("pc_1",   64'(dpc_1),   64'(e1.pc));
        chk("pc_2",   64'(dpc_2),   64'(e2.pc));
        chk("inst_1", 64'(dinst_1), 64'(e1.inst));
        chk("inst_2", 64'(dinst_2), 64'(e2.inst));
        chk("ua_1",   64'(dua_1),   64'(e1.ua));
        chk("ua_2",   64'(dua_2),   64'(e2.ua));
    endtask

    // One cycle: check outputs, drive inputs, update the reference, take the edge.
    task automatic step(input logic push, input logic [31:0] p1, input logic [31:0] i1,
                        input logic [31:0] i2, input logic u1, input logic [1:0] pp,
                        input logic fl);
        int n, pe;
        @(negedge clk);
        check_outputs();
        pipe_vld = push;
        pc_1 = p1;  pc_2 = p1 + 32'd4;
        inst_1 = i1; inst_2 = i2;
        ua_1 = u1;  ua_2 = 1'b0;
        pop = pp;   flush = fl;
        n = sb.size();
        if (fl) begin
            sb.delete();
        end else begin
            pe = (pp == 2'd3) ? 2 : int'(pp);
            if (pe > n) pe = n;
            repeat (pe) void'(sb.pop_front());
            if (push) begin
                if (n > DEPTH - 2) m_ovf = 1'b1;
                else begin
                    sb.push_back('{pc: p1, inst: i1, ua: u1});
                    sb.push_back('{pc: p1 + 32'd4, inst: i2, ua: 1'b0});
                end
            end
        end
    endtask

    task automatic idle(input logic [1:0] pp);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, pp, 1'b0);
    endtask

    task automatic push(input logic [31:0] p1, input logic [1:0] pp);
        step(1'b1, p1, p1 ^ 32'hA5A5_0013, ~p1, p1[3], pp, 1'b0);
    endtask

    initial begin
        // Test 1: reset and release
        repeat (2) begin @(negedge clk); check_outputs(); end
        @(negedge clk);
        rst_n = 1'b1;
        idle(2'd0);

        // Test 2: single bundle in and out
        step(1'b1, 32'h100, 32'h0000_0013, 32'h0010_0093, 1'b0, 2'd0, 1'b0);
        idle(2'd0);
        chk("t2_pc_1", 64'(dpc_1), 64'h100);
        chk("t2_inst_2", 64'(dinst_2), 64'h0010_0093);
        idle(2'd2);
        idle(2'd0);
        chk("t2_empty", 64'(count), 64'd0);

        // Test 3: fill to full and overflow
        push(32'h1000, 2'd0);
        push(32'h1008, 2'd0);
        push(32'h1010, 2'd0);
        idle(2'd0);
        chk("t3_cnt6_full", 64'(full), 64'd0);
        push(32'h1018, 2'd0);
        push(32'h2000, 2'd0);
        idle(2'd0);
        chk("t3_cnt8", 64'(count), 64'd8);
        chk("t3_ovf", 64'(ovf), 64'd1);
        chk("t3_head", 64'(dpc_1), 64'h1000);

        // Test 4: push with pop in the same cycle near full
        idle(2'd2);
        push(32'h1020, 2'd1);
        idle(2'd2);
        idle(2'd0);
        chk("t4_cnt5", 64'(count), 64'd5);
        chk("t4_full", 64'(full), 64'd0);
        idle(2'd3);
        idle(2'd2);
        idle(2'd2);
        idle(2'd0);

        // Test 5: streaming across the array wrap
        for (int i = 0; i < 10; i++)
            push(32'(i * 8), 2'd2);
        idle(2'd2);
        idle(2'd0);

        // Test 6: flush discards contents and the same-cycle push
        push(32'h3000, 2'd0);
        push(32'h3008, 2'd0);
        push(32'h3010, 2'd0);
        step(1'b1, 32'h3018, 32'h1, 32'h2, 1'b1, 2'd1, 1'b1);
        idle(2'd0);
        chk("t6_flushed", 64'(vld_1), 64'd0);
        push(32'h200, 2'd0);
        idle(2'd0);
        chk("t6_head", 64'(dpc_1), 64'h200);
        idle(2'd2);
        idle(2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
